// File: rtl/button_cmd_scheduler.sv
// Button command scheduler: press/repeat detection per button,
// round-robin arbitration and a small command FIFO with valid/ready drain.
module button_cmd_scheduler #(
  parameter int NUM_BTN = 4,
  parameter int ID_W = 2,
  parameter int FIFO_DEPTH = 4,
  parameter bit REPEAT_EN = 1'b1,
  parameter int HOLD_CYCLES = 25000000,
  parameter int REPEAT_CYCLES = 5000000,
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic               CLOCK,
  input  logic               Reset,
  input  logic [NUM_BTN-1:0] ButtonIn,
  output logic               CmdValid,
  output logic [ID_W-1:0]    CmdId,
  output logic               CmdRepeat,
  input  logic               CmdReady,
  output logic [LVL_W-1:0]   FifoLevel,
  output logic               Overflow
);

  localparam int MAX_CNT =
    (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W = $clog2(MAX_CNT + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HELD = 1'b1;

  logic [NUM_BTN-1:0] btnState;
  logic [CNT_W-1:0]   holdCnt [NUM_BTN];
  logic [NUM_BTN-1:0] pressReq;
  logic [NUM_BTN-1:0] rptReq;
  logic [NUM_BTN-1:0] anyReq;

  logic [NUM_BTN-1:0] pending;
  logic [NUM_BTN-1:0] pendRpt;
  logic [ID_W-1:0]    lastGrant;
  logic               overflowQ;

  logic               grantValid;
  logic [ID_W-1:0]    grantIdx;
  logic [NUM_BTN-1:0] grantMask;
  logic [NUM_BTN-1:0] dropMask;

  logic [ID_W:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wrPtr;
  logic [PTR_W-1:0]   rdPtr;
  logic [LVL_W-1:0]   level;
  logic               notEmpty;
  logic               pop;
  logic               canPush;
  logic               push;

  // Press and repeat requests decoded from the current button state
  always_comb begin
    pressReq = '0;
    rptReq = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      pressReq[i] = (btnState[i] == IDLE) && ButtonIn[i];
      rptReq[i] = REPEAT_EN && (btnState[i] == HELD) &&
                  ButtonIn[i] && (holdCnt[i] == CNT_W'(1));
    end
    anyReq = pressReq | rptReq;
  end

  // Per-button IDLE/HELD tracking with the hold/repeat countdown
  always_ff @(posedge CLOCK) begin
    if (Reset) begin
      btnState <= '0;
      for (int i = 0; i < NUM_BTN; i++)
        holdCnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        case (btnState[i])
          IDLE: begin
            if (ButtonIn[i]) begin
              btnState[i] <= HELD;
              holdCnt[i] <= CNT_W'(HOLD_CYCLES);
            end
          end
          default: begin
            if (!ButtonIn[i]) begin
              btnState[i] <= IDLE;
            end else if (REPEAT_EN) begin
              if (holdCnt[i] == CNT_W'(1))
                holdCnt[i] <= CNT_W'(REPEAT_CYCLES);
              else
                holdCnt[i] <= holdCnt[i] - CNT_W'(1);
            end
          end
        endcase
      end
    end
  end

  assign notEmpty = (level != '0);
  assign pop = notEmpty && CmdReady;
  assign canPush = (level < LVL_W'(FIFO_DEPTH)) || pop;

  // Round-robin search upward from the index after the last grant
  always_comb begin
    int j;
    j = 0;
    grantValid = 1'b0;
    grantIdx = '0;
    if (canPush) begin
      for (int k = 1; k <= NUM_BTN; k++) begin
        j = (int'(lastGrant) + k) % NUM_BTN;
        if (!grantValid && pending[j]) begin
          grantValid = 1'b1;
          grantIdx = ID_W'(j);
        end
      end
    end
  end

  assign grantMask = grantValid ? (NUM_BTN'(1) << grantIdx) : '0;
  assign dropMask = anyReq & pending & ~grantMask;
  assign push = grantValid;

  // Pending request bits, their repeat flags, grant history, overflow
  always_ff @(posedge CLOCK) begin
    if (Reset) begin
      pending <= '0;
      pendRpt <= '0;
      lastGrant <= ID_W'(NUM_BTN - 1);
      overflowQ <= 1'b0;
    end else begin
      pending <= (pending & ~grantMask) | anyReq;
      for (int i = 0; i < NUM_BTN; i++) begin
        if (anyReq[i] && !dropMask[i])
          pendRpt[i] <= rptReq[i];
      end
      if (|dropMask)
        overflowQ <= 1'b1;
      if (grantValid)
        lastGrant <= grantIdx;
    end
  end

  // Command FIFO storage, pointers and occupancy
  always_ff @(posedge CLOCK) begin
    if (Reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      level <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wrPtr] <= {pendRpt[grantIdx], grantIdx};
        wrPtr <= wrPtr + PTR_W'(1);
      end
      if (pop)
        rdPtr <= rdPtr + PTR_W'(1);
      if (push && !pop)
        level <= level + LVL_W'(1);
      else if (!push && pop)
        level <= level - LVL_W'(1);
    end
  end

  assign CmdValid = notEmpty;
  assign CmdId = notEmpty ? mem[rdPtr][ID_W-1:0] : '0;
  assign CmdRepeat = notEmpty ? mem[rdPtr][ID_W] : 1'b0;
  assign FifoLevel = level;
  assign Overflow = overflowQ;

endmodule

// File: tb/tb_button_cmd_scheduler.sv
// Testbench for button_cmd_scheduler: a queue-based reference model
// checks the main instance every cycle; a second instance covers no-repeat/overflow.
module tb_button_cmd_scheduler;

  localparam int HOLD = 8;
  localparam int RPT = 4;

  logic       CLOCK;
  logic       rst, rdy;
  logic [3:0] btn;
  logic       CmdValid, CmdRepeat, Overflow;
  logic [1:0] CmdId;
  logic [2:0] FifoLevel;

  logic       rst2, rdy2;
  logic [3:0] btn2;
  logic       CmdValid2, CmdRepeat2, Overflow2;
  logic [1:0] CmdId2;
  logic [1:0] FifoLevel2;

  int passCnt = 0;
  int totalCnt = 0;
  int cyc = 0;

  button_cmd_scheduler #(
    .NUM_BTN(4), .ID_W(2), .FIFO_DEPTH(4), .REPEAT_EN(1'b1),
    .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(RPT)
  ) dut (
    .CLOCK(CLOCK), .Reset(rst), .ButtonIn(btn),
    .CmdValid(CmdValid), .CmdId(CmdId), .CmdRepeat(CmdRepeat),
    .CmdReady(rdy), .FifoLevel(FifoLevel), .Overflow(Overflow)
  );

  button_cmd_scheduler #(
    .NUM_BTN(4), .ID_W(2), .FIFO_DEPTH(2), .REPEAT_EN(1'b0),
    .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(RPT)
  ) dut2 (
    .CLOCK(CLOCK), .Reset(rst2), .ButtonIn(btn2),
    .CmdValid(CmdValid2), .CmdId(CmdId2), .CmdRepeat(CmdRepeat2),
    .CmdReady(rdy2), .FifoLevel(FifoLevel2), .Overflow(Overflow2)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  // reference model state
  int qId[$];
  bit qRpt[$];
  bit pend[4];
  bit pendR[4];
  bit was[4];
  int age[4];
  int lastG;
  bit ovf;

  task automatic modelEdge(input logic [3:0] b, input logic r,
                           input logic rs);
    bit popM, canPushM;
    int g;
    bit req[4];
    bit rr[4];
    if (rs) begin
      qId.delete();
      qRpt.delete();
      for (int i = 0; i < 4; i++) begin
        pend[i] = 0; pendR[i] = 0; was[i] = 0; age[i] = 0;
      end
      lastG = 3;
      ovf = 0;
      return;
    end
    popM = (qId.size() > 0) && r;
    canPushM = (qId.size() < 4) || popM;
    g = -1;
    if (canPushM)
      for (int k = 1; k <= 4; k++)
        if (g < 0 && pend[(lastG + k) % 4]) g = (lastG + k) % 4;
    for (int i = 0; i < 4; i++) begin
      req[i] = 0; rr[i] = 0;
      if (b[i] && !was[i]) begin
        was[i] = 1; age[i] = 0; req[i] = 1;
      end else if (b[i]) begin
        age[i]++;
        if (age[i] >= HOLD && (age[i] - HOLD) % RPT == 0) begin
          req[i] = 1; rr[i] = 1;
        end
      end else begin
        was[i] = 0;
      end
    end
    if (popM) begin
      void'(qId.pop_front());
      void'(qRpt.pop_front());
    end
    if (g >= 0) begin
      qId.push_back(g);
      qRpt.push_back(pendR[g]);
      pend[g] = 0;
      lastG = g;
    end
    for (int i = 0; i < 4; i++)
      if (req[i]) begin
        if (pend[i]) ovf = 1;
        else begin pend[i] = 1; pendR[i] = rr[i]; end
      end
  endtask

  // one clock on the main instance, compared against the model
  task automatic cycleMain(input logic [3:0] b, input logic r,
                           input logic rs);
    logic       eV, eR;
    logic [1:0] eI;
    logic [2:0] eL;
    btn = b; rdy = r; rst = rs;
    @(posedge CLOCK);
    modelEdge(b, r, rs);
    #1;
    cyc++;
    eV = qId.size() > 0;
    eI = eV ? 2'(qId[0]) : 2'd0;
    eR = eV ? qRpt[0] : 1'b0;
    eL = 3'(qId.size());
    totalCnt++;
    if (CmdValid !== eV)
      $display("FAIL valid cyc=%0d got=%b want=%b", cyc, CmdValid, eV);
    else passCnt++;
    totalCnt++;
    if (CmdId !== eI)
      $display("FAIL id cyc=%0d got=%0d want=%0d", cyc, CmdId, eI);
    else passCnt++;
    totalCnt++;
    if (CmdRepeat !== eR)
      $display("FAIL repeat cyc=%0d got=%b want=%b", cyc, CmdRepeat, eR);
    else passCnt++;
    totalCnt++;
    if (FifoLevel !== eL)
      $display("FAIL level cyc=%0d got=%0d want=%0d", cyc, FifoLevel, eL);
    else passCnt++;
    totalCnt++;
    if (Overflow !== ovf)
      $display("FAIL overflow cyc=%0d got=%b want=%b", cyc, Overflow, ovf);
    else passCnt++;
  endtask

  task automatic cyc2(input logic [3:0] b, input logic r, input logic rs);
    btn2 = b; rdy2 = r; rst2 = rs;
    @(posedge CLOCK);
    #1;
  endtask

  task automatic test_reset();
    cycleMain(4'b0000, 1'b0, 1'b1);
    cycleMain(4'b0000, 1'b0, 1'b1);
    totalCnt++;
    if ({CmdValid, CmdId, CmdRepeat, FifoLevel, Overflow} !== 8'd0)
      $display("FAIL reset_outputs got=%b want=0",
               {CmdValid, CmdId, CmdRepeat, FifoLevel, Overflow});
    else passCnt++;
  endtask

  task automatic test_single_press();
    int firstAt, vcnt;
    logic [1:0] id;
    logic rp;
    firstAt = -1; vcnt = 0; id = 2'd3; rp = 1'b1;
    cycleMain(4'b0000, 1'b1, 1'b1);
    for (int n = 0; n < 9; n++) begin
      cycleMain((n < 3) ? 4'b0001 : 4'b0000, 1'b1, 1'b0);
      if (CmdValid) begin
        vcnt++;
        if (firstAt < 0) begin firstAt = n; id = CmdId; rp = CmdRepeat; end
      end
    end
    totalCnt++;
    if (vcnt != 1) $display("FAIL single_count got=%0d want=1", vcnt);
    else passCnt++;
    totalCnt++;
    if (firstAt != 1) $display("FAIL single_latency got=%0d want=1", firstAt);
    else passCnt++;
    totalCnt++;
    if (id !== 2'd0 || rp !== 1'b0)
      $display("FAIL single_head got=%0d/%b want=0/0", id, rp);
    else passCnt++;
  endtask

  task automatic test_all_press();
    int ids[$];
    int exp4[4] = '{0, 1, 2, 3};
    bit anyRpt;
    anyRpt = 0;
    cycleMain(4'b0000, 1'b0, 1'b1);
    cycleMain(4'b1111, 1'b0, 1'b0);
    for (int n = 0; n < 4; n++) cycleMain(4'b0000, 1'b0, 1'b0);
    totalCnt++;
    if (FifoLevel !== 3'd4) $display("FAIL fill_level got=%0d want=4", FifoLevel);
    else passCnt++;
    for (int n = 0; n < 5; n++) begin
      if (CmdValid) begin
        ids.push_back(int'(CmdId));
        if (CmdRepeat) anyRpt = 1;
      end
      cycleMain(4'b0000, 1'b1, 1'b0);
    end
    totalCnt++;
    if (ids.size() != 4 || anyRpt)
      $display("FAIL rr_count got=%0d/%b want=4/0", ids.size(), anyRpt);
    else passCnt++;
    for (int n = 0; n < 4 && n < ids.size(); n++) begin
      totalCnt++;
      if (ids[n] != exp4[n])
        $display("FAIL rr_order[%0d] got=%0d want=%0d", n, ids[n], exp4[n]);
      else passCnt++;
    end
  endtask

  task automatic test_repeat(input int holdLen, input int expN);
    bit rec[$];
    bit badId;
    badId = 0;
    cycleMain(4'b0000, 1'b1, 1'b1);
    for (int n = 0; n < holdLen + 4; n++) begin
      cycleMain((n < holdLen) ? 4'b0100 : 4'b0000, 1'b1, 1'b0);
      if (CmdValid) begin
        rec.push_back(CmdRepeat);
        if (CmdId !== 2'd2) badId = 1;
      end
    end
    totalCnt++;
    if (rec.size() != expN || badId)
      $display("FAIL repeat_count hold=%0d got=%0d want=%0d", holdLen,
               rec.size(), expN);
    else passCnt++;
    for (int n = 0; n < rec.size() && n < expN; n++) begin
      totalCnt++;
      if (rec[n] != (n != 0))
        $display("FAIL repeat_flag[%0d] got=%b want=%b", n, rec[n], n != 0);
      else passCnt++;
    end
  endtask

  task automatic test_random();
    logic [3:0] rb;
    rb = 4'b0000;
    cycleMain(4'b0000, 1'b0, 1'b1);
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 5) == 0) rb[i] = ~rb[i];
      cycleMain(rb, $urandom_range(0, 2) != 0, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    cycleMain(4'b0000, 1'b0, 1'b1);
    cycleMain(4'b1111, 1'b0, 1'b0);
    for (int n = 0; n < 3; n++) cycleMain(4'b0001, 1'b0, 1'b0);
    totalCnt++;
    if (FifoLevel !== 3'd3) $display("FAIL mid_level got=%0d want=3", FifoLevel);
    else passCnt++;
    cycleMain(4'b0001, 1'b0, 1'b1);
    totalCnt++;
    if ({CmdValid, FifoLevel, Overflow} !== 5'd0)
      $display("FAIL mid_reset got=%b want=0", {CmdValid, FifoLevel, Overflow});
    else passCnt++;
    cycleMain(4'b0001, 1'b0, 1'b0);
    totalCnt++;
    if (CmdValid !== 1'b0) $display("FAIL mid_early got=%b want=0", CmdValid);
    else passCnt++;
    cycleMain(4'b0001, 1'b0, 1'b0);
    totalCnt++;
    if (CmdValid !== 1'b1 || CmdId !== 2'd0)
      $display("FAIL mid_press got=%b/%0d want=1/0", CmdValid, CmdId);
    else passCnt++;
  endtask

  task automatic test_no_repeat();
    int vcnt;
    logic [1:0] id;
    vcnt = 0; id = 2'd0;
    cyc2(4'b0000, 1'b1, 1'b1);
    for (int n = 0; n < 53; n++) begin
      cyc2((n < 50) ? 4'b0010 : 4'b0000, 1'b1, 1'b0);
      if (CmdValid2) begin vcnt++; id = CmdId2; end
    end
    totalCnt++;
    if (vcnt != 1 || id !== 2'd1)
      $display("FAIL norepeat got=%0d/%0d want=1/1", vcnt, id);
    else passCnt++;
  endtask

  task automatic test_overflow();
    cyc2(4'b0000, 1'b0, 1'b1);
    for (int n = 0; n < 6; n++)
      cyc2((n % 2 == 0) ? 4'b1000 : 4'b0000, 1'b0, 1'b0);
    totalCnt++;
    if (FifoLevel2 !== 2'd2 || Overflow2 !== 1'b0)
      $display("FAIL ovf_pre got=%0d/%b want=2/0", FifoLevel2, Overflow2);
    else passCnt++;
    cyc2(4'b1000, 1'b0, 1'b0);
    totalCnt++;
    if (Overflow2 !== 1'b1) $display("FAIL ovf_set got=%b want=1", Overflow2);
    else passCnt++;
    for (int n = 0; n < 6; n++) cyc2(4'b0000, 1'b1, 1'b0);
    totalCnt++;
    if (FifoLevel2 !== 2'd0 || Overflow2 !== 1'b1)
      $display("FAIL ovf_sticky got=%0d/%b want=0/1", FifoLevel2, Overflow2);
    else passCnt++;
    cyc2(4'b0000, 1'b0, 1'b1);
    totalCnt++;
    if (Overflow2 !== 1'b0) $display("FAIL ovf_clear got=%b want=0", Overflow2);
    else passCnt++;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b0; btn = 4'b0000;
    rst2 = 1'b1; rdy2 = 1'b0; btn2 = 4'b0000;
    test_reset();
    test_single_press();
    test_all_press();
    test_repeat(20, 4);
    test_repeat(16, 3);
    test_reset_mid();
    test_random();
    test_no_repeat();
    test_overflow();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
